cordic_sincos: RTL and testbench

CORDIC_SINCOS -- requirements
Module: cordic_sincos

---
 rtl/cordic_pkg.sv | 56 +++++
 rtl/cordic_stage.sv | 33 +++
 rtl/cordic_sincos.sv | 119 +++++++++++
 tb/tb_cordic_sincos.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared CORDIC constants, arctangent table, FSM state and output rounding helper
package cordic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        DONE = 2'd2
    } state_e;

    // x/y carry Q2.18 (two guard LSBs); z is Q2.16 with one extra headroom bit
    localparam logic signed [19:0] K_GAIN   = 20'sh26DD3;
    localparam logic signed [18:0] PI       = 19'sh3243F;
    localparam logic signed [18:0] PI_2     = 19'sh1921F;
    localparam logic signed [18:0] NEG_PI_2 = -19'sh1921F;
    localparam logic signed [19:0] SAT_POS  = 20'sh10000;
    localparam logic signed [19:0] SAT_NEG  = -20'sh10000;

    function automatic logic signed [18:0] atan_lut(input logic [3:0] idx);
        logic signed [18:0] a;
        case (idx)
            4'd0:    a = 19'sd51472;
            4'd1:    a = 19'sd30386;
            4'd2:    a = 19'sd16055;
            4'd3:    a = 19'sd8150;
            4'd4:    a = 19'sd4091;
            4'd5:    a = 19'sd2047;
            4'd6:    a = 19'sd1024;
            4'd7:    a = 19'sd512;
            4'd8:    a = 19'sd256;
            4'd9:    a = 19'sd128;
            4'd10:   a = 19'sd64;
            4'd11:   a = 19'sd32;
            4'd12:   a = 19'sd16;
            4'd13:   a = 19'sd8;
            4'd14:   a = 19'sd4;
            default: a = 19'sd2;
        endcase
        return a;
    endfunction

    // Drop the guard bits with round-to-nearest, clamp to +/-1.0, then undo the fold
    function automatic logic signed [17:0] round_sat(input logic signed [19:0] v, input logic neg);
        logic signed [19:0] r;
        r = (v + 20'sd2) >>> 2;
        if (r > SAT_POS) begin
            r = SAT_POS;
        end else if (r < SAT_NEG) begin
            r = SAT_NEG;
        end
        if (neg) begin
            r = -r;
        end
        return r[17:0];
    endfunction

endpackage

// File: rtl/cordic_stage.sv
// rtl/cordic_stage.sv - one combinational CORDIC rotation step
module cordic_stage
    import cordic_pkg::*;
(
    input  logic signed [19:0] x_i,
    input  logic signed [19:0] y_i,
    input  logic signed [18:0] z_i,
    input  logic        [3:0]  i_i,
    output logic signed [19:0] x_o,
    output logic signed [19:0] y_o,
    output logic signed [18:0] z_o
);

    logic signed [19:0] x_sh;
    logic signed [19:0] y_sh;
    logic signed [18:0] atan_i;

    always_comb begin
        x_sh   = x_i >>> i_i;
        y_sh   = y_i >>> i_i;
        atan_i = atan_lut(i_i);
        if (!z_i[18]) begin
            x_o = x_i - y_sh;
            y_o = y_i + x_sh;
            z_o = z_i - atan_i;
        end else begin
            x_o = x_i + y_sh;
            y_o = y_i - x_sh;
            z_o = z_i + atan_i;
        end
    end

endmodule

// File: rtl/cordic_sincos.sv
// rtl/cordic_sincos.sv - iterative CORDIC sine/cosine with valid/ready handshakes
module cordic_sincos
    import cordic_pkg::*;
#(
    parameter int ITER = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [17:0] angle_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [17:0] cos_out,
    output logic [17:0] sin_out
);

    localparam logic [4:0] ITER_L = 5'(ITER);

    state_e             state_q, state_d;
    logic signed [19:0] x_q, x_d, y_q, y_d;
    logic signed [18:0] z_q, z_d;
    logic        [4:0]  i_q, i_d;
    logic               neg_q, neg_d;
    logic signed [17:0] cos_q, cos_d, sin_q, sin_d;

    logic signed [19:0] x_nx, y_nx;
    logic signed [18:0] z_nx;
    logic signed [18:0] ang;

    cordic_stage u_stage (
        .x_i (x_q),
        .y_i (y_q),
        .z_i (z_q),
        .i_i (i_q[3:0]),
        .x_o (x_nx),
        .y_o (y_nx),
        .z_o (z_nx)
    );

    assign ang       = {angle_in[17], angle_in};
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign cos_out   = cos_q;
    assign sin_out   = sin_q;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        i_d     = i_q;
        neg_d   = neg_q;
        cos_d   = cos_q;
        sin_d   = sin_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Fold into [-pi/2, pi/2] where CORDIC converges; sin/cos flip sign
                    if (ang > PI_2) begin
                        z_d   = ang - PI;
                        neg_d = 1'b1;
                    end else if (ang < NEG_PI_2) begin
                        z_d   = ang + PI;
                        neg_d = 1'b1;
                    end else begin
                        z_d   = ang;
                        neg_d = 1'b0;
                    end
                    x_d     = K_GAIN;
                    y_d     = '0;
                    i_d     = '0;
                    state_d = ROT;
                end
            end
            ROT: begin
                if (i_q == ITER_L) begin
                    cos_d   = round_sat(x_q, neg_q);
                    sin_d   = round_sat(y_q, neg_q);
                    state_d = DONE;
                end else begin
                    x_d = x_nx;
                    y_d = y_nx;
                    z_d = z_nx;
                    i_d = i_q + 5'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            i_q     <= '0;
            neg_q   <= 1'b0;
            cos_q   <= '0;
            sin_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            i_q     <= i_d;
            neg_q   <= neg_d;
            cos_q   <= cos_d;
            sin_q   <= sin_d;
        end
    end

endmodule

// File: tb/tb_cordic_sincos.sv
// tb/tb_cordic_sincos.sv - directed self-checking bench for cordic_sincos
module tb_cordic_sincos;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] angle_in;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] cos_out;
    logic [17:0] sin_out;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    cordic_sincos #(.ITER(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .angle_in  (angle_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cos_out   (cos_out),
        .sin_out   (sin_out)
    );

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input logic signed [17:0] obs, input int exp);
        int  d;
        logic ok;
        d  = int'(obs) - exp;
        ok = (d >= -4) && (d <= 4);
        total++;
        assert (ok === 1'b1) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d+/-4", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [17:0] ang);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk_eq("in_ready_before_transfer", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        angle_in = ang;
        tick();
        in_valid = 1'b0;
        angle_in = 18'h15555;
    endtask

    task automatic wait_result(input string tag);
        int lat;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk_eq({tag, "_latency"}, lat, 32'd17);
    endtask

    task automatic run_angle(input string tag, input logic [17:0] ang, input int exp_cos, input int exp_sin);
        start(ang);
        wait_result(tag);
        chk_tol({tag, "_cos"}, cos_out, exp_cos);
        chk_tol({tag, "_sin"}, sin_out, exp_sin);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_eq({tag, "_ready_after_accept"}, {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    initial begin
        logic [17:0] hold_cos, hold_sin;
        logic        stable, seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        angle_in  = '0;
        out_ready = 1'b0;
        tick();
        tick();
        chk_eq("reset_outputs", {13'd0, out_valid, cos_out}, 32'd0);
        chk_eq("reset_sin", {14'd0, sin_out}, 32'd0);
        rst = 1'b0;
        tick();
        chk_eq("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

        run_angle("zero",     18'h00000,  65536,      0);
        // -pi/6 in Q2.16 is -34315
        run_angle("neg_pi6",  18'h379F5,  56756, -32768);
        run_angle("fold_1p9", 18'h1E666, -21187,  62017);
        run_angle("pi_2",     18'h1921F,      0,  65536);
        run_angle("neg_2p0",  18'h20000, -27273, -59593);
        run_angle("one",      18'h10000,  35409,  55147);

        // Back-pressure: result held, no new transfer accepted
        start(18'h10000);
        wait_result("bp");
        hold_cos = cos_out;
        hold_sin = sin_out;
        stable   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0];
            angle_in = 18'h00000;
            tick();
            if (cos_out !== hold_cos || sin_out !== hold_sin || in_ready !== 1'b0 || out_valid !== 1'b1)
                stable = 1'b0;
        end
        in_valid = 1'b0;
        chk_eq("bp_stable", {31'd0, stable}, 32'd1);
        chk_tol("bp_cos", cos_out, 35409);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_eq("bp_release", {30'd0, in_ready, out_valid}, 32'd2);

        // Reset while the eighth iteration (i=7) is executing
        start(18'h3C000);
        for (int k = 0; k < 7; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_eq("midrst_state", {30'd0, in_ready, out_valid}, 32'd2);
        chk_eq("midrst_cos", {14'd0, cos_out}, 32'd0);
        chk_eq("midrst_sin", {14'd0, sin_out}, 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk_eq("midrst_no_result", {31'd0, seen}, 32'd0);
        run_angle("after_rst", 18'h379F5, 56756, -32768);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
